// File: rtl/seq_alu.sv
// seq_alu: clocked ALU for the execute stage.
// Single-cycle logic/arith/compare ops plus iterative MUL, DIVU and REMU
// behind an in_valid/in_ready handshake. A result shows up as a one-cycle
// out_valid pulse. y and the flags hold their value until the next result.
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int OP_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             ovf,
  output logic             dz,
  output logic             bad_op
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [OP_W-1:0] OP_AND  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_OR   = OP_W'(1);
  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_SLT  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_SLTU = OP_W'(5);
  localparam logic [OP_W-1:0] OP_MUL  = OP_W'(6);
  localparam logic [OP_W-1:0] OP_DIVU = OP_W'(7);
  localparam logic [OP_W-1:0] OP_REMU = OP_W'(8);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;     // multiplicand (shifts left) / dividend->quotient
  logic [WIDTH-1:0] b_q, b_d;     // multiplier (shifts right) / divisor
  logic [WIDTH-1:0] acc_q, acc_d; // product accumulator
  logic [WIDTH-1:0] rem_q, rem_d; // partial remainder
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             zero_q, zero_d, ovf_q, ovf_d, dz_q, dz_d, bad_q, bad_d;

  logic [WIDTH-1:0] sum, diff, res;
  logic             res_ovf, res_dz, res_bad, b_zero;
  logic [WIDTH-1:0] mul_acc_nxt;
  logic [WIDTH:0]   div_tmp;
  logic             div_ge;
  logic [WIDTH-1:0] rem_nxt, q_nxt;

  // Single-cycle result, evaluated on the live inputs for the accept edge
  always_comb begin
    sum     = a + b;
    diff    = a - b;
    b_zero  = (b == '0);
    res     = '0;
    res_ovf = 1'b0;
    res_dz  = 1'b0;
    res_bad = 1'b0;
    case (op)
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_ADD: begin
        res     = sum;
        res_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        res     = diff;
        res_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT:  res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: res = {{(WIDTH-1){1'b0}}, a < b};
      OP_MUL:  res = '0;
      // Only reaches the result register when b==0
      OP_DIVU: begin res = '1; res_dz = 1'b1; end
      OP_REMU: begin res = a;  res_dz = 1'b1; end
      default: res_bad = 1'b1;
    endcase
  end

  // One shift-add step and one restoring-division step
  always_comb begin
    mul_acc_nxt = acc_q + (b_q[0] ? a_q : '0);
    div_tmp     = {rem_q, a_q[WIDTH-1]};
    div_ge      = (div_tmp >= {1'b0, b_q});
    // When div_ge holds the difference is below b, so WIDTH bits suffice
    rem_nxt     = div_ge ? (div_tmp[WIDTH-1:0] - b_q) : div_tmp[WIDTH-1:0];
    q_nxt       = {a_q[WIDTH-2:0], div_ge};
  end

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    y_d     = y_q;
    ovf_d   = ovf_q;
    dz_d    = dz_q;
    bad_d   = bad_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (op == OP_MUL) begin
            a_d     = a;
            b_d     = b;
            acc_d   = '0;
            cnt_d   = '0;
            op_d    = op;
            state_d = S_MUL;
          end else if ((op == OP_DIVU || op == OP_REMU) && !b_zero) begin
            a_d     = a;
            b_d     = b;
            rem_d   = '0;
            cnt_d   = '0;
            op_d    = op;
            state_d = S_DIV;
          end else begin
            y_d     = res;
            ovf_d   = res_ovf;
            dz_d    = res_dz;
            bad_d   = res_bad;
            state_d = S_DONE;
          end
        end
      end
      S_MUL: begin
        acc_d = mul_acc_nxt;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          y_d     = mul_acc_nxt;
          ovf_d   = 1'b0;
          dz_d    = 1'b0;
          bad_d   = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DIV: begin
        rem_d = rem_nxt;
        a_d   = q_nxt;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          y_d     = (op_q == OP_REMU) ? rem_nxt : q_nxt;
          ovf_d   = 1'b0;
          dz_d    = 1'b0;
          bad_d   = 1'b0;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // y_d only differs from y_q when a result lands, so zero tracks it exactly
    zero_d = (y_d == '0);
  end

  // State, operand and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      y_q     <= '0;
      zero_q  <= 1'b1;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      y_q     <= y_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
      bad_q   <= bad_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign y         = y_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;
  assign dz        = dz_q;
  assign bad_op    = bad_q;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: a 32-bit and an 8-bit instance share the
// clock and reset. Expected results come from a plain-arithmetic model.
module tb_seq_alu;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        v32 = 1'b0, r32, ov32, z32, o32, dz32, bd32;
  logic [3:0]  op32 = '0;
  logic [31:0] a32 = '0, b32 = '0, y32;
  logic        v8 = 1'b0, r8, ov8, z8, o8, dz8, bd8;
  logic [3:0]  op8 = '0;
  logic [7:0]  a8 = '0, b8 = '0, y8;

  seq_alu #(.WIDTH(32), .OP_W(4)) u32 (
    .clk(clk), .rst_n(rst_n), .in_valid(v32), .in_ready(r32), .op(op32),
    .a(a32), .b(b32), .out_valid(ov32), .y(y32), .zero(z32), .ovf(o32),
    .dz(dz32), .bad_op(bd32));

  seq_alu #(.WIDTH(8), .OP_W(4)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(r8), .op(op8),
    .a(a8), .b(b8), .out_valid(ov8), .y(y8), .zero(z8), .ovf(o8),
    .dz(dz8), .bad_op(bd8));

  typedef struct {
    longint unsigned y;
    bit zero, ovf, dz, bad;
    int lat;
    time t;
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(string nm, longint unsigned act, longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: the ALU rules in w-bit modular / true signed arithmetic
  function automatic exp_t model(int w, int op, longint unsigned ai, longint unsigned bi);
    exp_t e;
    longint unsigned m = (64'd1 << w) - 1;
    longint unsigned a = ai & m;
    longint unsigned b = bi & m;
    longint maxs = (longint'(1) << (w - 1)) - 1;
    longint mins = -(longint'(1) << (w - 1));
    longint sa = (a > longint'(maxs)) ? longint'(a) - (longint'(1) << w) : longint'(a);
    longint sb = (b > longint'(maxs)) ? longint'(b) - (longint'(1) << w) : longint'(b);
    longint sr;
    e = '{default: 0};
    case (op)
      0: e.y = a & b;
      1: e.y = a | b;
      2: begin sr = sa + sb; e.y = (a + b) & m; e.ovf = (sr > maxs) || (sr < mins); end
      3: begin sr = sa - sb; e.y = (a - b) & m; e.ovf = (sr > maxs) || (sr < mins); end
      4: e.y = (sa < sb) ? 1 : 0;
      5: e.y = (a < b) ? 1 : 0;
      6: e.y = (a * b) & m;
      7: if (b == 0) begin e.y = m; e.dz = 1; end else e.y = a / b;
      8: if (b == 0) begin e.y = a; e.dz = 1; end else e.y = a % b;
      default: e.bad = 1;
    endcase
    e.zero = (e.y == 0);
    e.lat  = (op == 6 || ((op == 7 || op == 8) && b != 0)) ? w + 1 : 1;
    return e;
  endfunction

  // Drive one request on the chosen instance once it is ready
  task automatic issue(int w, int op, longint unsigned a, longint unsigned b);
    exp_t e;
    int n = 0;
    @(negedge clk);
    while (!(w == 32 ? r32 : r8) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL issue_w%0d: in_ready got 0 expected 1", w);
      return;
    end
    e = model(w, op, a, b);
    if (w == 32) begin
      v32 = 1'b1; op32 = 4'(op); a32 = 32'(a); b32 = 32'(b);
    end else begin
      v8 = 1'b1; op8 = 4'(op); a8 = 8'(a); b8 = 8'(b);
    end
    @(posedge clk);
    e.t = $time;
    if (w == 32) q32.push_back(e); else q8.push_back(e);
    #1;
    if (w == 32) v32 = 1'b0; else v8 = 1'b0;
  endtask

  task automatic mon(int w, longint unsigned y, bit z, bit o, bit d, bit bd, bit rdy);
    exp_t e;
    string p = (w == 32) ? "w32" : "w8";
    int lat;
    if ((w == 32) ? (q32.size() == 0) : (q8.size() == 0)) begin
      checks++;
      errors++;
      $display("FAIL %s out_valid: got 1 expected 0 (nothing pending)", p);
      return;
    end
    if (w == 32) e = q32.pop_front(); else e = q8.pop_front();
    lat = int'(($time - e.t - 5) / 10) + 1;
    chk({p, " y"}, y, e.y);
    chk({p, " zero"}, z, e.zero);
    chk({p, " ovf"}, o, e.ovf);
    chk({p, " dz"}, d, e.dz);
    chk({p, " bad_op"}, bd, e.bad);
    chk({p, " in_ready_at_out"}, rdy, 0);
    chk({p, " latency"}, longint'(lat), longint'(e.lat));
  endtask

  // Monitor: pop and compare whenever an instance presents a result
  always @(negedge clk) begin
    if (ov32) mon(32, 64'(y32), z32, o32, dz32, bd32, r32);
    if (ov8)  mon(8, 64'(y8), z8, o8, dz8, bd8, r8);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int op, n;
    longint unsigned ra, rb;

    // Reset state
    #12;
    chk("rst in_ready", r32, 1);
    chk("rst out_valid", ov32, 0);
    chk("rst y", y32, 0);
    chk("rst zero", z32, 1);
    chk("rst flags", {o32, dz32, bd32}, 0);
    chk("rst8 in_ready", r8, 1);
    chk("rst8 zero", z8, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed, WIDTH=32
    issue(32, 3, 8, 41);
    issue(32, 3, 41, 41);
    issue(32, 4, 32'hFFFFFFFD, 32'hFFFFFFFB);
    issue(32, 5, 32'hFFFFFFFD, 32'hFFFFFFFB);
    issue(32, 4, 32'hFFFFFFFB, 32'hFFFFFFFD);
    issue(32, 4, 1, 32'hFFFFFFFF);
    issue(32, 5, 1, 32'hFFFFFFFF);
    issue(32, 2, 32'h7FFFFFFF, 1);
    issue(32, 3, 32'h80000000, 1);
    issue(32, 0, 32'hF0F0_1234, 32'h0FF0_FFFF);
    issue(32, 1, 32'hF0F0_1234, 32'h0FF0_0000);
    issue(32, 6, 12345, 6789);
    issue(32, 7, 100, 7);
    issue(32, 8, 100, 7);
    issue(32, 7, 100, 0);
    issue(32, 8, 1234, 0);
    issue(32, 15, 5, 6);
    issue(32, 9, 5, 6);
    issue(32, 7, 32'hFFFFFFFF, 1);

    // in_valid held with a different op and new operands while MUL runs
    issue(32, 6, 32'h0001_0003, 32'h0000_0101);
    @(negedge clk);
    v32 = 1'b1; op32 = 4'd2; a32 = 32'd77; b32 = 32'd99;
    repeat (29) @(negedge clk);
    v32 = 1'b0;

    // Async reset in the middle of a MUL: no result may follow
    issue(32, 6, 12345, 6789);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst in_ready", r32, 1);
    chk("midrst out_valid", ov32, 0);
    chk("midrst y", y32, 0);
    chk("midrst zero", z32, 1);
    q32.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);

    // Directed, WIDTH=8
    issue(8, 6, 15, 17);
    issue(8, 2, 8'h7F, 1);
    issue(8, 3, 8'h80, 1);
    issue(8, 7, 200, 7);
    issue(8, 8, 200, 7);
    issue(8, 7, 200, 0);
    issue(8, 4, 8'hFD, 8'h01);
    issue(8, 5, 8'hFD, 8'h01);

    // Random mix on both widths
    for (int i = 0; i < 80; i++) begin
      op = $urandom_range(0, 11);
      if (op == 11) op = 15;
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = rb & 32'hF;
      issue((i % 2 == 0) ? 32 : 8, op, ra, rb);
    end

    // Drain outstanding results
    n = 0;
    while ((q32.size() != 0 || q8.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain pending", q32.size() + q8.size(), 0);
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
